collision_detector: RTL and testbench

Consumer side of the obstacle/player interface: samples the player and obstacle rectangles on each `game_en` tick and decides whether they overlap. Issues the `collision` request that the obstacle controller consumes to respawn its obstacle. Tracks lives, an invulnerability cooldown and game-over for the renderer and top-level game FSM. Sits between the player/obstacle position generators and the renderer, clocked from the 50 MHz system clock.

---
 rtl/collision_pkg.sv | 15 +
 rtl/rect_overlap.sv | 36 +++
 rtl/collision_detector.sv | 161 ++++++++++++++++
 tb/tb_collision_detector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// collision_pkg: shared types and defaults for the collision detector.
//   state_e          - detector FSM encoding (ARMED/HIT/COOLDOWN/OVER)
//   SCREEN_W_DEFAULT - default visible screen width in pixels
package collision_pkg;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_HIT      = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_OVER     = 2'd3
  } state_e;

  localparam int unsigned SCREEN_W_DEFAULT = 640;

endpackage

// File: rtl/rect_overlap.sv
// rect_overlap: purely combinational test of whether two axis-aligned
// rectangles (top-left x/y plus width/height, 10-bit each) overlap.
// Far edges are computed in 11 bits so they never wrap. Rectangles that
// only share an edge do not overlap.
//   a_x, a_y, a_w, a_h : first rectangle
//   b_x, b_y, b_w, b_h : second rectangle
//   overlap            : 1 when the interiors intersect
module rect_overlap (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] a_w,
  input  logic [9:0] a_h,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] b_w,
  input  logic [9:0] b_h,
  output logic       overlap
);

  logic [10:0] a_right;
  logic [10:0] a_bottom;
  logic [10:0] b_right;
  logic [10:0] b_bottom;

  always_comb begin
    a_right  = {1'b0, a_x} + {1'b0, a_w};
    a_bottom = {1'b0, a_y} + {1'b0, a_h};
    b_right  = {1'b0, b_x} + {1'b0, b_w};
    b_bottom = {1'b0, b_y} + {1'b0, b_h};
    overlap  = ({1'b0, b_x} < a_right)  &&
               ({1'b0, a_x} < b_right)  &&
               ({1'b0, b_y} < a_bottom) &&
               ({1'b0, a_y} < b_bottom);
  end

endmodule

// File: rtl/collision_detector.sv
// collision_detector: samples player and obstacle rectangles on each
// game_en tick, confirms overlaps over CONFIRM_TICKS consecutive ticks,
// raises a one-tick collision request, then runs an invulnerability
// cooldown. Tracks lives, a saturating hit counter and game-over.
//   clk, rst          : system clock, async active-high reset
//   game_en           : one-cycle slow game tick
//   restart           : one-cycle new-game request (any state, any cycle)
//   player_*/obstacle_*: rectangles, top-left plus size
//   collision         : hit request, high for exactly one game_en cycle
//   invuln            : high during cooldown
//   lives, hit_count  : remaining lives, total hits (saturating)
//   game_over         : high once the last life has been consumed
module collision_detector
  import collision_pkg::*;
#(
  parameter int unsigned CONFIRM_TICKS  = 2,
  parameter int unsigned COOLDOWN_TICKS = 30,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned SCREEN_W       = SCREEN_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic       restart,
  input  logic [9:0] player_x_pos,
  input  logic [9:0] player_y_pos,
  input  logic [9:0] player_width,
  input  logic [9:0] player_height,
  input  logic [9:0] obstacle_x_pos,
  input  logic [9:0] obstacle_y_pos,
  input  logic [9:0] obstacle_width,
  input  logic [9:0] obstacle_height,
  output logic       collision,
  output logic       invuln,
  output logic [2:0] lives,
  output logic [7:0] hit_count,
  output logic       game_over
);

  // confirm_q counts overlapping ticks already seen; the tick that finds
  // it at CONFIRM_LAST is the confirming one.
  localparam logic [2:0]  CONFIRM_LAST = 3'(CONFIRM_TICKS - 1);
  localparam logic [7:0]  COOL_LOAD    = 8'(COOLDOWN_TICKS);
  localparam logic [2:0]  LIVES_LOAD   = 3'(START_LIVES);
  localparam logic [10:0] SCREEN_LIM   = 11'(SCREEN_W);

  state_e     state_q,     state_d;
  logic [2:0] confirm_q,   confirm_d;
  logic [7:0] cool_q,      cool_d;
  logic [2:0] lives_q,     lives_d;
  logic [7:0] hit_q,       hit_d;
  logic       collision_q, collision_d;
  logic       invuln_q,    invuln_d;
  logic       game_over_q, game_over_d;

  logic rect_hit;
  logic overlap;

  rect_overlap u_rect_overlap (
    .a_x     (player_x_pos),
    .a_y     (player_y_pos),
    .a_w     (player_width),
    .a_h     (player_height),
    .b_x     (obstacle_x_pos),
    .b_y     (obstacle_y_pos),
    .b_w     (obstacle_width),
    .b_h     (obstacle_height),
    .overlap (rect_hit)
  );

  // Off-screen obstacles never collide.
  assign overlap = rect_hit && ({1'b0, obstacle_x_pos} < SCREEN_LIM);

  always_comb begin
    state_d   = state_q;
    confirm_d = confirm_q;
    cool_d    = cool_q;
    lives_d   = lives_q;
    hit_d     = hit_q;

    if (restart) begin
      state_d   = ST_ARMED;
      confirm_d = '0;
      cool_d    = '0;
      lives_d   = LIVES_LOAD;
      hit_d     = '0;
    end else if (game_en) begin
      unique case (state_q)
        ST_ARMED: begin
          if (!overlap) begin
            confirm_d = '0;
          end else if (confirm_q == CONFIRM_LAST) begin
            state_d   = ST_HIT;
            confirm_d = '0;
            lives_d   = (lives_q != '0) ? lives_q - 3'd1 : lives_q;
            hit_d     = (hit_q == '1) ? hit_q : hit_q + 8'd1;
          end else begin
            confirm_d = confirm_q + 3'd1;
          end
        end
        ST_HIT: begin
          // This tick is the one the obstacle controller consumes.
          if (lives_q == '0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_COOLDOWN;
            cool_d  = COOL_LOAD;
          end
        end
        ST_COOLDOWN: begin
          confirm_d = '0;
          cool_d    = cool_q - 8'd1;
          if (cool_q <= 8'd1) begin
            state_d = ST_ARMED;
            cool_d  = '0;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_ARMED;
        end
      endcase
    end

    // Outputs are registered copies of the next-state decode.
    collision_d = (state_d == ST_HIT);
    invuln_d    = (state_d == ST_COOLDOWN);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARMED;
      confirm_q   <= '0;
      cool_q      <= '0;
      lives_q     <= LIVES_LOAD;
      hit_q       <= '0;
      collision_q <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      confirm_q   <= confirm_d;
      cool_q      <= cool_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      collision_q <= collision_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign collision = collision_q;
  assign invuln    = invuln_q;
  assign lives     = lives_q;
  assign hit_count = hit_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_detector.sv
module tb_collision_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_en;
  logic       restart;
  logic [9:0] px, py, pw, ph;
  logic [9:0] ox, oy, ow, oh;
  logic       collision;
  logic       invuln;
  logic [2:0] lives;
  logic [7:0] hit_count;
  logic       game_over;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  collision_detector #(
    .CONFIRM_TICKS (2),
    .COOLDOWN_TICKS(30),
    .START_LIVES   (3),
    .SCREEN_W      (640)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .game_en        (game_en),
    .restart        (restart),
    .player_x_pos   (px),
    .player_y_pos   (py),
    .player_width   (pw),
    .player_height  (ph),
    .obstacle_x_pos (ox),
    .obstacle_y_pos (oy),
    .obstacle_width (ow),
    .obstacle_height(oh),
    .collision      (collision),
    .invuln         (invuln),
    .lives          (lives),
    .hit_count      (hit_count),
    .game_over      (game_over)
  );

  typedef struct {
    string      name;
    logic       c;
    logic       i;
    logic [2:0] l;
    logic [7:0] h;
    logic       o;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [9:0] px, py, pw, ph, ox, oy, ow, oh;
    logic       rs;
    logic       c, i;
    logic [2:0] l;
    logic [7:0] h;
    logic       o;
  } vec_t;

  function automatic vec_t mk(input int a_x, a_y, a_w, a_h, b_x, b_y, b_w, b_h,
                              input int rs, c, i, l, h, o);
    vec_t v;
    v.px = 10'(a_x); v.py = 10'(a_y); v.pw = 10'(a_w); v.ph = 10'(a_h);
    v.ox = 10'(b_x); v.oy = 10'(b_y); v.ow = 10'(b_w); v.oh = 10'(b_h);
    v.rs = 1'(rs);   v.c = 1'(c);     v.i = 1'(i);
    v.l  = 3'(l);    v.h = 8'(h);     v.o = 1'(o);
    return v;
  endfunction

  task automatic push(input string name, input logic c, input logic i,
                      input logic [2:0] l, input logic [7:0] h, input logic o);
    exp_t e;
    e.name = name; e.c = c; e.i = i; e.l = l; e.h = h; e.o = o;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: DUT output with no expectation queued");
      return;
    end
    e = sb.pop_front();
    if ({collision, invuln, lives, hit_count, game_over} !== {e.c, e.i, e.l, e.h, e.o}) begin
      n_fail++;
      $display("FAIL %s: got c=%0b inv=%0b lives=%0d hits=%0d over=%0b, expected c=%0b inv=%0b lives=%0d hits=%0d over=%0b",
               e.name, collision, invuln, lives, hit_count, game_over,
               e.c, e.i, e.l, e.h, e.o);
    end
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h);
    px = 10'(x); py = 10'(y); pw = 10'(w); ph = 10'(h);
  endtask

  task automatic set_obst(input int x, input int y, input int w, input int h);
    ox = 10'(x); oy = 10'(y); ow = 10'(w); oh = 10'(h);
  endtask

  // One game_en cycle; outputs are sampled 1 ns after the edge.
  task automatic tick(input logic rs);
    @(negedge clk);
    game_en = 1'b1;
    restart = rs;
    @(posedge clk);
    #1;
    game_en = 1'b0;
    restart = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic restart_only();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic t_exp(input string name, input logic rs, input logic c, input logic i,
                       input logic [2:0] l, input logic [7:0] h, input logic o);
    push(name, c, i, l, h, o);
    tick(rs);
    check();
  endtask

  task automatic now_exp(input string name, input logic c, input logic i,
                         input logic [2:0] l, input logic [7:0] h, input logic o);
    push(name, c, i, l, h, o);
    check();
  endtask

  vec_t tbl[14];

  initial begin
    rst = 1'b1; game_en = 1'b0; restart = 1'b0;
    set_player(100, 285, 30, 30);
    set_obst(400, 100, 30, 30);

    tbl[0]  = mk(100, 285, 30, 30, 400, 100, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[1]  = mk(100, 285, 30, 30, 110, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[2]  = mk(100, 285, 30, 30, 200, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[3]  = mk(100, 285, 30, 30, 110, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[4]  = mk(100, 285, 30, 30, 130, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[5]  = mk(100, 285, 30, 30, 130, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[6]  = mk(100, 285, 30, 30,  70, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[7]  = mk(100, 285, 30, 30,  70, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[8]  = mk(100, 285, 30, 30, 110, 315, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[9]  = mk(100, 285, 30, 30, 110, 315, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[10] = mk(620, 285, 40, 30, 640, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[11] = mk(620, 285, 40, 30, 640, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[12] = mk(100, 285, 30, 30, 110, 290, 30, 30, 0, 0, 0, 3, 0, 0);
    tbl[13] = mk(100, 285, 30, 30, 110, 290, 30, 30, 0, 1, 0, 2, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    now_exp("reset_values", 0, 0, 3, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    now_exp("after_reset_idle", 0, 0, 3, 0, 0);

    for (int k = 0; k < 14; k++) begin
      px = tbl[k].px; py = tbl[k].py; pw = tbl[k].pw; ph = tbl[k].ph;
      ox = tbl[k].ox; oy = tbl[k].oy; ow = tbl[k].ow; oh = tbl[k].oh;
      push($sformatf("table_row_%0d", k), tbl[k].c, tbl[k].i, tbl[k].l, tbl[k].h, tbl[k].o);
      tick(tbl[k].rs);
      check();
    end

    // collision holds between ticks, then clears on the consuming tick
    for (int k = 0; k < 3; k++) begin
      idle();
      now_exp("hit1_held_idle", 1, 0, 2, 1, 0);
    end
    t_exp("hit1_consumed", 0, 0, 1, 2, 1, 0);

    // overlap persists throughout a 30-tick cooldown
    for (int k = 1; k <= 30; k++)
      t_exp($sformatf("cooldown1_tick_%0d", k), 0, 0, (k < 30), 2, 1, 0);
    t_exp("post_cool_tick1", 0, 0, 0, 2, 1, 0);
    t_exp("post_cool_tick2_hit2", 0, 1, 0, 1, 2, 0);
    set_obst(400, 100, 30, 30);
    t_exp("hit2_consumed", 0, 0, 1, 1, 2, 0);
    for (int k = 1; k <= 30; k++)
      t_exp($sformatf("cooldown2_tick_%0d", k), 0, 0, (k < 30), 1, 2, 0);

    // last life
    set_obst(110, 290, 30, 30);
    t_exp("hit3_confirm1", 0, 0, 0, 1, 2, 0);
    t_exp("hit3_confirm2", 0, 1, 0, 0, 3, 0);
    t_exp("hit3_consumed_over", 0, 0, 0, 0, 3, 1);
    for (int k = 0; k < 3; k++)
      t_exp("over_frozen", 0, 0, 0, 0, 3, 1);

    restart_only();
    now_exp("restart_from_over", 0, 0, 3, 0, 0);
    t_exp("rearmed_tick1", 0, 0, 0, 3, 0, 0);
    t_exp("rearmed_tick2_hit", 0, 1, 0, 2, 1, 0);

    // restart mid-HIT drops collision next cycle
    restart_only();
    now_exp("restart_mid_hit", 0, 0, 3, 0, 0);

    // restart beats a confirming tick in the same cycle
    t_exp("pre_confirm_tick", 0, 0, 0, 3, 0, 0);
    t_exp("restart_vs_confirm", 1, 0, 0, 3, 0, 0);
    t_exp("confirm_cleared_by_restart", 0, 0, 0, 3, 0, 0);
    t_exp("hit_after_restart", 0, 1, 0, 2, 1, 0);

    // async reset mid-HIT, checked before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    now_exp("async_rst_mid_hit", 0, 0, 3, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    now_exp("after_async_rst", 0, 0, 3, 0, 0);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
